// File: rtl/fir_pkg.sv
// Shared constants, width helpers and coefficient-bank state for the transposed-form FIR.
package fir_pkg;

    typedef enum logic {CLEAN = 1'b0, DIRTY = 1'b1} coef_state_t;

    localparam int HPF13_TAPS = 13;
    localparam int DEFAULT_HPF13 [HPF13_TAPS] =
        '{10, 37, 59, -72, -477, -988, 2863, -988, -477, -72, 59, 37, 10};

    function automatic int addr_w(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Reset contents of both banks: the legacy HPF only when the tap count matches it.
    function automatic int default_coef(input int taps, input int k);
        return (taps == HPF13_TAPS && k >= 0 && k < HPF13_TAPS) ? DEFAULT_HPF13[k] : 0;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: shadow bank written per tap, copied to active bank on commit.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int COEF_W = 13,
    parameter int TAPS   = 13,
    parameter int AW     = addr_w(TAPS)
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Coef_wr,
    input  logic [AW-1:0]            Coef_addr,
    input  logic signed [COEF_W-1:0] Coef_data,
    input  logic                     Coef_commit,
    output logic                     Coef_pending,
    output logic                     Coef_err,
    output logic signed [COEF_W-1:0] Active [TAPS]
);

    coef_state_t state, state_nxt;
    logic signed [COEF_W-1:0] shadow [TAPS];
    logic wr_ok;

    assign wr_ok        = Coef_wr && (int'(Coef_addr) < TAPS);
    assign Coef_pending = (state == DIRTY);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= CLEAN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAN:   if (wr_ok) state_nxt = DIRTY;
            DIRTY:   if (Coef_commit && !wr_ok) state_nxt = CLEAN;
            default: state_nxt = CLEAN;
        endcase
    end

    // Commit copies the pre-write shadow, so a same-edge write stays pending for the next commit.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Coef_err <= 1'b0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                shadow[i] <= COEF_W'(default_coef(TAPS, int'(i)));
                Active[i] <= COEF_W'(default_coef(TAPS, int'(i)));
            end
        end else begin
            Coef_err <= Coef_wr && !wr_ok;
            for (int unsigned i = 0; i < TAPS; i++) begin
                if (Coef_commit) Active[i] <= shadow[i];
                if (wr_ok && (Coef_addr == AW'(i))) shadow[i] <= Coef_data;
            end
        end
    end

endmodule

// File: rtl/fir_tf_param.sv
// Parametrised transposed-form FIR with double-buffered coefficients and rounded output.
// Define FIR_SAT_EN to clamp out-of-range results; otherwise the output wraps.
module fir_tf_param
    import fir_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int COEF_W     = 13,
    parameter int TAPS       = 13,
    parameter int OUT_W      = 14,
    parameter int FRAC_SHIFT = 6
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       In_valid,
    input  logic signed [DATA_W-1:0]   Xin,
    input  logic                       Flush,
    input  logic                       Coef_wr,
    input  logic [addr_w(TAPS)-1:0]    Coef_addr,
    input  logic signed [COEF_W-1:0]   Coef_data,
    input  logic                       Coef_commit,
    output logic                       Coef_pending,
    output logic                       Coef_err,
    output logic                       Out_valid,
    output logic signed [OUT_W-1:0]    Out
);

    localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);
    localparam int PW    = DATA_W + COEF_W;

    localparam logic signed [ACC_W:0] RND     = (ACC_W + 1)'(1) <<< (FRAC_SHIFT - 1);
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    logic signed [COEF_W-1:0] coef   [TAPS];
    logic signed [PW-1:0]     prod   [TAPS];
    logic signed [ACC_W-1:0]  dly    [TAPS-1];
    logic signed [ACC_W-1:0]  dly_in [TAPS-1];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W:0]    rnd;
    logic signed [ACC_W:0]    shifted;
    logic signed [OUT_W-1:0]  out_nxt;

    fir_coef_bank #(
        .COEF_W (COEF_W),
        .TAPS   (TAPS)
    ) u_bank (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Coef_wr      (Coef_wr),
        .Coef_addr    (Coef_addr),
        .Coef_data    (Coef_data),
        .Coef_commit  (Coef_commit),
        .Coef_pending (Coef_pending),
        .Coef_err     (Coef_err),
        .Active       (coef)
    );

    for (genvar k = 0; k < TAPS; k++) begin : g_prod
        assign prod[k] = PW'(coef[k]) * PW'(Xin);
    end

    // dly[0] holds the oldest-tap product; dly[TAPS-2] is the nearly complete sum.
    for (genvar k = 0; k < TAPS - 1; k++) begin : g_chain
        if (k == 0) begin : g_first
            assign dly_in[k] = ACC_W'(prod[TAPS-1]);
        end else begin : g_add
            assign dly_in[k] = dly[k-1] + ACC_W'(prod[TAPS-1-k]);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int unsigned i = 0; i < TAPS - 1; i++) dly[i] <= '0;
        end else if (Flush) begin
            for (int unsigned i = 0; i < TAPS - 1; i++) dly[i] <= '0;
        end else if (In_valid) begin
            for (int unsigned i = 0; i < TAPS - 1; i++) dly[i] <= dly_in[i];
        end
    end

    assign acc = dly[TAPS-2] + ACC_W'(prod[0]);

    always_comb begin
        rnd     = (ACC_W + 1)'(acc) + RND;
        shifted = rnd >>> FRAC_SHIFT;
`ifdef FIR_SAT_EN
        if (shifted > SAT_MAX) begin
            out_nxt = OUT_W'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            out_nxt = OUT_W'(SAT_MIN);
        end else begin
            out_nxt = OUT_W'(shifted);
        end
`else
        out_nxt = OUT_W'(shifted);
`endif
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Out       <= '0;
            Out_valid <= 1'b0;
        end else if (Flush) begin
            Out_valid <= 1'b0;
        end else if (In_valid) begin
            Out       <= out_nxt;
            Out_valid <= 1'b1;
        end else begin
            Out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_tf_param.sv
// Self-checking bench for fir_tf_param against a direct-convolution reference model.
module tb_fir_tf_param;

    localparam int DATA_W     = 8;
    localparam int COEF_W     = 13;
    localparam int TAPS       = 13;
    localparam int OUT_W      = 14;
    localparam int FRAC_SHIFT = 6;
    localparam int AW         = $clog2(TAPS);
    localparam int HPF [13]   = '{10, 37, 59, -72, -477, -988, 2863, -988, -477, -72, 59, 37, 10};

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    logic In_valid = 1'b0, Flush = 1'b0, Coef_wr = 1'b0, Coef_commit = 1'b0;
    logic signed [DATA_W-1:0] Xin = '0;
    logic [AW-1:0] Coef_addr = '0;
    logic signed [COEF_W-1:0] Coef_data = '0;
    logic Coef_pending, Coef_err, Out_valid;
    logic signed [OUT_W-1:0] Out;

    int checks = 0;
    int errors = 0;

    // Reference state: banks, sample history and the bank each past sample was filtered with.
    int act [TAPS];
    int shd [TAPS];
    int hx  [TAPS];
    int hh  [TAPS][TAPS];
    int exp_out;
    bit exp_valid, exp_pend, exp_err;

    fir_tf_param #(
        .DATA_W     (DATA_W),
        .COEF_W     (COEF_W),
        .TAPS       (TAPS),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .In_valid     (In_valid),
        .Xin          (Xin),
        .Flush        (Flush),
        .Coef_wr      (Coef_wr),
        .Coef_addr    (Coef_addr),
        .Coef_data    (Coef_data),
        .Coef_commit  (Coef_commit),
        .Coef_pending (Coef_pending),
        .Coef_err     (Coef_err),
        .Out_valid    (Out_valid),
        .Out          (Out)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic int model_scale(input longint acc);
        longint r, lim;
        r   = (acc + (longint'(1) << (FRAC_SHIFT - 1))) >>> FRAC_SHIFT;
        lim = longint'(1) << (OUT_W - 1);
`ifdef FIR_SAT_EN
        if (r > lim - 1) r = lim - 1;
        if (r < -lim) r = -lim;
`else
        r = r % (2 * lim);
        if (r < 0) r = r + 2 * lim;
        if (r >= lim) r = r - 2 * lim;
`endif
        return int'(r);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < TAPS; k++) begin
            act[k] = HPF[k];
            shd[k] = HPF[k];
            hx[k]  = 0;
            for (int j = 0; j < TAPS; j++) hh[k][j] = 0;
        end
        exp_out = 0; exp_valid = 0; exp_pend = 0; exp_err = 0;
    endfunction

    function automatic void model_edge(input bit iv, input int x, input bit fl,
                                       input bit wr, input int addr, input int data, input bit cm);
        longint acc;
        bit ok;
        ok = wr && (addr < TAPS);
        exp_err = wr && !ok;
        if (fl) begin
            for (int k = 0; k < TAPS; k++) hx[k] = 0;
            exp_valid = 0;
        end else if (iv) begin
            for (int k = TAPS - 1; k > 0; k--) begin
                hx[k] = hx[k-1];
                hh[k] = hh[k-1];
            end
            hx[0] = x;
            hh[0] = act;
            acc = 0;
            for (int k = 0; k < TAPS; k++) acc += longint'(hh[k][k]) * longint'(hx[k]);
            exp_out = model_scale(acc);
            exp_valid = 1;
        end else begin
            exp_valid = 0;
        end
        if (cm) act = shd;
        if (ok) shd[addr] = data;
        exp_pend = ok ? 1'b1 : (cm ? 1'b0 : exp_pend);
    endfunction

    task automatic step(input bit iv, input int x, input bit fl,
                        input bit wr, input int addr, input int data, input bit cm);
        In_valid = iv; Xin = DATA_W'(x); Flush = fl;
        Coef_wr = wr; Coef_addr = AW'(addr); Coef_data = COEF_W'(data); Coef_commit = cm;
        @(posedge Clk);
        model_edge(iv, x, fl, wr, addr, data, cm);
        #1;
        In_valid = 1'b0; Flush = 1'b0; Coef_wr = 1'b0; Coef_commit = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        checks++; if (Out !== 0) begin errors++; $display("FAIL reset_out got %0d want 0", Out); end
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", Out_valid); end
        checks++; if (Coef_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", Coef_pending); end
        checks++; if (Coef_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", Coef_err); end
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic test_impulse(input string name, input int first0, input int first1);
        step(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < TAPS + 2; i++) begin
            int want;
            step(1, (i == 0) ? 64 : 0, 0, 0, 0, 0, 0);
            want = (i >= TAPS) ? 0 : (i == 0) ? first0 : (i == 1) ? first1 : HPF[i];
            checks++; if (Out !== want) begin errors++; $display("FAIL %s_out[%0d] got %0d want %0d", name, i, Out, want); end
            checks++; if (Out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid[%0d] got %b want 1", name, i, Out_valid); end
        end
    endtask

    task automatic test_step();
        step(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < TAPS + 4; i++) begin
            step(1, 127, 0, 0, 0, 0, 0);
            checks++; if (Out !== exp_out) begin errors++; $display("FAIL step_out[%0d] got %0d want %0d", i, Out, exp_out); end
        end
        checks++; if (Out !== 2) begin errors++; $display("FAIL step_settled got %0d want 2", Out); end
    endtask

    task automatic test_sat_coefs();
        int want_pos, want_neg;
`ifdef FIR_SAT_EN
        want_pos = 8191; want_neg = -8192;
`else
        want_pos = 7334; want_neg = -8166;
`endif
        for (int k = 0; k < TAPS; k++) begin
            step(0, 0, 0, 1, k, 4095, 0);
            checks++; if (Coef_pending !== 1'b1) begin errors++; $display("FAIL load_pending[%0d] got %b want 1", k, Coef_pending); end
        end
        step(0, 0, 1, 0, 0, 0, 1);
        checks++; if (Coef_pending !== 1'b0) begin errors++; $display("FAIL commit_pending got %b want 0", Coef_pending); end
        for (int i = 0; i < TAPS + 2; i++) begin
            step(1, 127, 0, 0, 0, 0, 0);
            checks++; if (Out !== exp_out) begin errors++; $display("FAIL big_pos[%0d] got %0d want %0d", i, Out, exp_out); end
        end
        checks++; if (Out !== want_pos) begin errors++; $display("FAIL big_pos_final got %0d want %0d", Out, want_pos); end
        for (int i = 0; i < TAPS + 2; i++) begin
            step(1, -128, 0, 0, 0, 0, 0);
            checks++; if (Out !== exp_out) begin errors++; $display("FAIL big_neg[%0d] got %0d want %0d", i, Out, exp_out); end
        end
        checks++; if (Out !== want_neg) begin errors++; $display("FAIL big_neg_final got %0d want %0d", Out, want_neg); end
        for (int k = 0; k < TAPS; k++) step(0, 0, 0, 1, k, HPF[k], 0);
        step(0, 0, 1, 0, 0, 0, 1);
    endtask

    task automatic test_gaps();
        int n = 0;
        int last = 0;
        step(0, 0, 1, 0, 0, 0, 0);
        last = Out;
        for (int i = 0; i < 3 * (TAPS + 1); i++) begin
            bit iv = (i % 3 == 0);
            step(iv, (i == 0) ? 64 : 0, 0, 0, 0, 0, 0);
            if (iv) begin
                int want = (n < TAPS) ? HPF[n] : 0;
                checks++; if (Out !== want) begin errors++; $display("FAIL gap_out[%0d] got %0d want %0d", n, Out, want); end
                checks++; if (Out_valid !== 1'b1) begin errors++; $display("FAIL gap_valid[%0d] got %b want 1", i, Out_valid); end
                last = want;
                n++;
            end else begin
                checks++; if (Out !== last) begin errors++; $display("FAIL gap_hold[%0d] got %0d want %0d", i, Out, last); end
                checks++; if (Out_valid !== 1'b0) begin errors++; $display("FAIL gap_idle[%0d] got %b want 0", i, Out_valid); end
            end
        end
    endtask

    task automatic test_coef_err();
        step(0, 0, 0, 1, 13, 1234, 0);
        checks++; if (Coef_err !== 1'b1) begin errors++; $display("FAIL err13_pulse got %b want 1", Coef_err); end
        checks++; if (Coef_pending !== 1'b0) begin errors++; $display("FAIL err13_pending got %b want 0", Coef_pending); end
        step(0, 0, 0, 1, 15, -999, 0);
        checks++; if (Coef_err !== 1'b1) begin errors++; $display("FAIL err15_pulse got %b want 1", Coef_err); end
        step(0, 0, 0, 0, 0, 0, 1);
        checks++; if (Coef_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", Coef_err); end
        test_impulse("err_banks", HPF[0], HPF[1]);
    endtask

    task automatic test_commit_write();
        step(0, 0, 0, 1, 0, 100, 0);
        checks++; if (Coef_pending !== 1'b1) begin errors++; $display("FAIL cw_pending1 got %b want 1", Coef_pending); end
        step(0, 0, 0, 1, 1, 200, 1);
        checks++; if (Coef_pending !== 1'b1) begin errors++; $display("FAIL cw_pending2 got %b want 1", Coef_pending); end
        test_impulse("cw_partial", 100, HPF[1]);
        step(0, 0, 0, 0, 0, 0, 1);
        checks++; if (Coef_pending !== 1'b0) begin errors++; $display("FAIL cw_pending3 got %b want 0", Coef_pending); end
        test_impulse("cw_full", 100, 200);
        step(0, 0, 0, 1, 0, HPF[0], 0);
        step(0, 0, 0, 1, 1, HPF[1], 0);
        step(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_flush();
        step(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, (i == 0) ? 64 : 0, 0, 0, 0, 0, 0);
        step(1, 64, 1, 0, 0, 0, 0);
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", Out_valid); end
        checks++; if (Out !== HPF[4]) begin errors++; $display("FAIL flush_hold got %0d want %0d", Out, HPF[4]); end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            checks++; if (Out !== 0) begin errors++; $display("FAIL flush_zero[%0d] got %0d want 0", i, Out); end
        end
        test_impulse("post_flush", HPF[0], HPF[1]);
    endtask

    task automatic test_async_reset();
        step(0, 0, 0, 1, 0, 555, 0);
        for (int i = 0; i < 4; i++) step(1, (i == 0) ? 64 : 0, 0, 0, 0, 0, 0);
        #2;
        Rst_n = 1'b0;
        #1;
        checks++; if (Out !== 0) begin errors++; $display("FAIL arst_out got %0d want 0", Out); end
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", Out_valid); end
        checks++; if (Coef_pending !== 1'b0) begin errors++; $display("FAIL arst_pending got %b want 0", Coef_pending); end
        model_reset();
        @(negedge Clk);
        Rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 1);
        test_impulse("post_arst", HPF[0], HPF[1]);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit iv = ($urandom_range(0, 9) < 7);
            bit fl = ($urandom_range(0, 19) == 0);
            bit wr = ($urandom_range(0, 9) < 3);
            bit cm = ($urandom_range(0, 9) == 0);
            int x  = int'($urandom_range(0, 255)) - 128;
            int ad = int'($urandom_range(0, 15));
            int d  = int'($urandom_range(0, 8191)) - 4096;
            step(iv, x, fl, wr, ad, d, cm);
            checks++; if (Out !== exp_out) begin errors++; $display("FAIL rnd_out[%0d] got %0d want %0d", i, Out, exp_out); end
            checks++; if (Out_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", i, Out_valid, exp_valid); end
            checks++; if (Coef_pending !== exp_pend) begin errors++; $display("FAIL rnd_pending[%0d] got %b want %b", i, Coef_pending, exp_pend); end
            checks++; if (Coef_err !== exp_err) begin errors++; $display("FAIL rnd_err[%0d] got %b want %b", i, Coef_err, exp_err); end
        end
    endtask

    initial begin
        test_reset();
        test_impulse("impulse", HPF[0], HPF[1]);
        test_step();
        test_sat_coefs();
        test_gaps();
        test_coef_err();
        test_commit_write();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
